sys_array_split_walker: RTL
===========================

Name: sys_array_split_walker

Overview:
- Consumer of the split table produced by the systolic-array splitter; reads the table once it is complete.
- Issues every leaf tile (operation == connect_none) to the array controller as a valid/ready task stream.
- After all leaf results are acknowledged, issues merge operations bottom-up (descending index) for all inner nodes.
- Sits between the splitter and the array/accumulator control path.

Parameters:
- OUT_SIZE, 100, number of entries in the split table; index width is 16 bits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- table_ready  in  1  split table valid, from splitter ready
- table  in  split_type[OUT_SIZE]  split table, held stable while table_ready = 1
- first_none  in  16  index of first leaf entry
- last  in  16  entry count; valid indices are 0..last-1
- task_valid  out  1  leaf task available
- task_ready  in  1  consumer accepts leaf task
- task_data  out  split_type  leaf entry, copied whole
- leaf_done  in  1  one-cycle pulse, one leaf result finished
- comb_valid  out  1  merge operation available
- comb_ready  in  1  consumer accepts merge
- comb_data  out  split_type  inner-node entry (operation, to_n1, to_n2, O window)
- busy  out  1  walker not in IDLE or DONE
- done  out  1  all leaves and merges issued
- err  out  1  sticky protocol or bounds error

Behaviour:
- Reset (async, active-high): state = IDLE; all outputs 0; all counters 0; table_ready edge register 0.
- Start condition: rising edge of table_ready, detected via a registered copy, while in IDLE. Any other edge is ignored.
- Bounds: lim = min(last, OUT_SIZE). If last > OUT_SIZE, set err and use lim.
- States:
  - IDLE: on start, idx <= first_none and go to LEAF_SCAN. If first_none >= lim, go directly to DRAIN.
  - LEAF_SCAN: examine one entry per cycle.
    - If table[idx].operation == connect_none: register task_data, set task_valid, go to LEAF_WAIT.
    - Otherwise idx++.
    - When idx reaches lim: go to DRAIN.
  - LEAF_WAIT: hold task_valid and task_data stable until task_ready is sampled high. On accept: issued++, idx++, task_valid = 0 in the next cycle, back to LEAF_SCAN (or DRAIN if idx+1 == lim).
  - DRAIN: wait until completed == issued, then idx <= lim-1 and go to COMB_SCAN. If lim == 0, go to DONE.
  - COMB_SCAN: examine one entry per cycle, descending.
    - If operation != connect_none: register comb_data, set comb_valid, go to COMB_WAIT.
    - Otherwise, if idx == 0 go to DONE, else idx--.
  - COMB_WAIT: hold comb_valid and comb_data until comb_ready. On accept: go to DONE if idx == 0, else idx-- and back to COMB_SCAN.
  - DONE: done = 1, busy = 0. When table_ready falls, done is cleared and the state returns to IDLE.
- Ordering: children always have a higher index than their parent, so descending order guarantees children are merged before the parent.
- Latency:
  - First task_valid appears 2 cycles after the table_ready rising edge if table[first_none] is a leaf.
  - Back-to-back leaves: one task per 2 cycles minimum.
- leaf_done:
  - Counted in any state except IDLE.
  - A pulse when completed == issued (also counting a same-cycle accept) is spurious: set err, do not count.
  - A simultaneous accept and leaf_done both update their counters in the same cycle.
- Counters are 16 bits; issued never exceeds lim, so no wrap occurs.
- table_ready falling mid-walk: abort. Return to IDLE, drop valids, clear counters, set err. done is not set.
- Reset mid-operation: immediate return to reset values; a new rising edge of table_ready is required to start.
- busy = state not in {IDLE, DONE}.

Decomposition:
- Shared package sys_array_pkg holds:
  - operation_types (connect_none, connect_sum, connect_hor, connect_vert)
  - split_type
- The splitter imports the same package.
- One natural sub-module, split_table_scanner: an index register with up/down direction, a match predicate (leaf / non-leaf), and end detection against lim or 0. It is instantiated once and re-loaded between the two phases.

Test Plan:
- Single entry 0 = none, first_none = 0, last = 1 -> one task with n = 0; after one leaf_done, no comb_valid; done = 1; err = 0.
- Entries 0 = vert(1,2), 1 = none, 2 = none; first_none = 1, last = 3 -> tasks n = 1 then n = 2. Two leaf_done pulses -> one comb with n = 0, op = connect_vert, to_n1 = 1, to_n2 = 2; then done.
- Entries 0 = hor(1,2), 1 = sum(3,4), 2 = none, 3 = none, 4 = none; first_none = 2, last = 5 -> tasks 2, 3, 4; combs n = 1 then n = 0; done.
- Backpressure: task_ready held low for 5 cycles -> task_valid stays 1, task_data unchanged, issued unchanged; accept occurs on the 6th cycle.
- last = 120 with OUT_SIZE = 100 -> err = 1; no entry beyond index 99 is read.
- Spurious leaf_done while issued = completed = 1 -> err = 1, completed stays 1.
- Reset asserted in COMB_WAIT -> all outputs 0 asynchronously. Holding table_ready high after reset release produces no restart; a new rising edge restarts the walk.

Source files
------------

// File: rtl/sys_array_pkg.sv
// Shared split-table types for the systolic-array splitter and walker.
// Holds operation codes, the split entry layout and walker states.
package sys_array_pkg;

  localparam int IDX_W = 16;

  typedef enum logic [1:0] {
    connect_none,
    connect_sum,
    connect_hor,
    connect_vert
  } operation_types;

  typedef struct packed {
    logic [15:0]    n;
    operation_types operation;
    logic [15:0]    to_n1;
    logic [15:0]    to_n2;
    logic [7:0]     o_row;
    logic [7:0]     o_col;
    logic [7:0]     o_rows;
    logic [7:0]     o_cols;
  } split_type;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAF_SCAN,
    S_LEAF_WAIT,
    S_DRAIN,
    S_COMB_SCAN,
    S_COMB_WAIT,
    S_DONE
  } walk_state_e;

endpackage

// File: rtl/sys_array_split_walker_if.sv
// Walker <-> array controller bundle: leaf task stream, merge stream,
// leaf completion pulse. master = walker, slave = controller.
interface sys_array_split_walker_if;
  import sys_array_pkg::*;

  logic      task_valid;
  logic      task_ready;
  split_type task_data;
  logic      leaf_done;
  logic      comb_valid;
  logic      comb_ready;
  split_type comb_data;

  modport master (
    output task_valid, task_data,
    output comb_valid, comb_data,
    input  task_ready, comb_ready, leaf_done
  );

  modport slave (
    input  task_valid, task_data,
    input  comb_valid, comb_data,
    output task_ready, comb_ready, leaf_done
  );

endinterface

// File: rtl/split_table_scanner.sv
// Up/down index over the split table with leaf/inner match and end flag.
// Ports: clr/load/step control, down dir, lim bound; entry, match, at_end.
module split_table_scanner
  import sys_array_pkg::*;
#(
  parameter int OUT_SIZE = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  split_type        split_table [OUT_SIZE],
  input  logic             clr,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  input  logic             step,
  input  logic             down,
  input  logic [IDX_W-1:0] lim,
  output split_type        entry,
  output logic             match,
  output logic             at_end
);

  localparam int AW =
    (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [IDX_W-1:0] SIZE =
    IDX_W'(OUT_SIZE);

  logic [IDX_W-1:0] idx;
  logic             leaf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (load) begin
      idx <= load_val;
    end else if (step) begin
      idx <= down ? idx - IDX_W'(1)
                  : idx + IDX_W'(1);
    end
  end

  // Never index past the table, whatever idx holds.
  always_comb begin
    entry = '0;
    if (idx < SIZE) begin
      entry = split_table[idx[AW-1:0]];
    end
  end

  assign leaf   = entry.operation == connect_none;
  assign match  = down ? !leaf : leaf;
  assign at_end = down ? (idx == '0)
                       : (idx + IDX_W'(1) >= lim);

endmodule

// File: rtl/sys_array_split_walker.sv
// Walks a finished split table: issues leaf tasks, waits for all results,
// then issues merges bottom-up. Ports: table in, bus (tasks/merges), status.
module sys_array_split_walker
  import sys_array_pkg::*;
#(
  parameter int OUT_SIZE = 100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     table_ready,
  input  split_type                split_table [OUT_SIZE],
  input  logic [IDX_W-1:0]         first_none,
  input  logic [IDX_W-1:0]         last,
  sys_array_split_walker_if.master bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [IDX_W-1:0] SIZE =
    IDX_W'(OUT_SIZE);

  walk_state_e      state;
  logic             tr_q;
  logic             armed;
  logic [IDX_W-1:0] issued;
  logic [IDX_W-1:0] completed;
  logic [IDX_W-1:0] lim;
  logic             start;
  logic             accept;
  logic             abort;
  logic             spurious;

  logic             sc_load;
  logic [IDX_W-1:0] sc_val;
  logic             sc_step;
  logic             sc_down;
  split_type        sc_entry;
  logic             sc_match;
  logic             sc_end;

  assign lim = (last > SIZE) ? SIZE : last;

  // armed needs table_ready seen low since reset,
  // so a level held across reset never restarts.
  assign start  = table_ready && !tr_q && armed;
  assign accept = (state == S_LEAF_WAIT)
               && bus.task_ready;
  assign busy   = !(state == S_IDLE
               || state == S_DONE);
  assign abort  = busy && !table_ready;

  // A result with nothing outstanding,
  // counting an accept in the same cycle.
  assign spurious = completed
                 == issued + IDX_W'(accept);

  assign sc_down = (state == S_COMB_SCAN)
                || (state == S_COMB_WAIT);

  always_comb begin
    sc_load = 1'b0;
    sc_val  = first_none;
    sc_step = 1'b0;
    unique case (state)
      S_IDLE:      sc_load = start;
      S_LEAF_SCAN: sc_step = !sc_match && !sc_end;
      S_LEAF_WAIT: sc_step = bus.task_ready && !sc_end;
      S_DRAIN: begin
        sc_load = (lim != '0)
               && (completed == issued);
        sc_val  = lim - IDX_W'(1);
      end
      S_COMB_SCAN: sc_step = !sc_match && !sc_end;
      S_COMB_WAIT: sc_step = bus.comb_ready && !sc_end;
      default:     ;
    endcase
  end

  split_table_scanner #(
    .OUT_SIZE (OUT_SIZE)
  ) u_scan (
    .clk         (clk),
    .reset       (reset),
    .split_table (split_table),
    .clr         (abort),
    .load        (sc_load),
    .load_val    (sc_val),
    .step        (sc_step),
    .down        (sc_down),
    .lim         (lim),
    .entry       (sc_entry),
    .match       (sc_match),
    .at_end      (sc_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      tr_q           <= 1'b0;
      armed          <= 1'b0;
      issued         <= '0;
      completed      <= '0;
      bus.task_valid <= 1'b0;
      bus.task_data  <= '0;
      bus.comb_valid <= 1'b0;
      bus.comb_data  <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      tr_q <= table_ready;
      if (!table_ready) armed <= 1'b1;

      if (state != S_IDLE && bus.leaf_done) begin
        if (spurious) err <= 1'b1;
        else completed <= completed + IDX_W'(1);
      end
      if (accept) issued <= issued + IDX_W'(1);

      if (abort) begin
        state          <= S_IDLE;
        issued         <= '0;
        completed      <= '0;
        bus.task_valid <= 1'b0;
        bus.comb_valid <= 1'b0;
        err            <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              issued    <= '0;
              completed <= '0;
              if (last > SIZE) err <= 1'b1;
              state <= (first_none >= lim)
                     ? S_DRAIN : S_LEAF_SCAN;
            end
          end
          S_LEAF_SCAN: begin
            if (sc_match) begin
              bus.task_data  <= sc_entry;
              bus.task_valid <= 1'b1;
              state          <= S_LEAF_WAIT;
            end else if (sc_end) begin
              state <= S_DRAIN;
            end
          end
          S_LEAF_WAIT: begin
            if (bus.task_ready) begin
              bus.task_valid <= 1'b0;
              state <= sc_end ? S_DRAIN : S_LEAF_SCAN;
            end
          end
          S_DRAIN: begin
            if (lim == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (completed == issued) begin
              state <= S_COMB_SCAN;
            end
          end
          S_COMB_SCAN: begin
            if (sc_match) begin
              bus.comb_data  <= sc_entry;
              bus.comb_valid <= 1'b1;
              state          <= S_COMB_WAIT;
            end else if (sc_end) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
          S_COMB_WAIT: begin
            if (bus.comb_ready) begin
              bus.comb_valid <= 1'b0;
              if (sc_end) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_COMB_SCAN;
              end
            end
          end
          S_DONE: begin
            if (!table_ready) begin
              state <= S_IDLE;
              done  <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
